// File: rtl/game_set_if.sv
// Settings bundle carried from the level setup stage to the settings latch.
interface game_set_if;
    logic [4:0]  button_num;
    logic [6:0]  button_size;
    logic [9:0]  board_size;
    logic [10:0] board_xpos;
    logic [10:0] board_ypos;

    modport master (
        output button_num,
        output button_size,
        output board_size,
        output board_xpos,
        output board_ypos
    );

    modport slave (
        input button_num,
        input button_size,
        input board_size,
        input board_xpos,
        input board_ypos
    );
endinterface

// File: rtl/game_level_setup.sv
// Turns a difficulty-level request into board geometry and pulses latch_en
// once the geometry bundle is stable.
module game_level_setup #(
    parameter int H_ACTIVE = 1024,
    parameter int V_ACTIVE = 768
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       level_valid,
    input  logic [1:0] level,
    output logic       busy,
    output logic       latch_en,
    game_set_if.master out
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        CENTER,
        DONE
    } state_t;

    localparam logic [10:0] H_W = 11'(H_ACTIVE);
    localparam logic [10:0] V_W = 11'(V_ACTIVE);

    state_t      state;
    logic [4:0]  num;
    logic [4:0]  cnt;
    logic [6:0]  size;
    logic [9:0]  acc;
    logic [4:0]  tbl_num;
    logic [6:0]  tbl_size;
    logic [10:0] acc_ext;
    logic [10:0] x_pos;
    logic [10:0] y_pos;

    always_comb begin
        tbl_num  = 5'd0;
        tbl_size = 7'd0;
        case (level)
            2'd1: begin tbl_num = 5'd8;  tbl_size = 7'd64; end
            2'd2: begin tbl_num = 5'd12; tbl_size = 7'd48; end
            2'd3: begin tbl_num = 5'd16; tbl_size = 7'd40; end
            default: begin tbl_num = 5'd0; tbl_size = 7'd0; end
        endcase
    end

    // A board at least as large as the screen pins its position to the origin.
    assign acc_ext = {1'b0, acc};
    assign x_pos   = (acc_ext >= H_W) ? 11'd0 : ((H_W - acc_ext) >> 1);
    assign y_pos   = (acc_ext >= V_W) ? 11'd0 : ((V_W - acc_ext) >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            busy            <= 1'b0;
            latch_en        <= 1'b0;
            num             <= 5'd0;
            size            <= 7'd0;
            acc             <= 10'd0;
            cnt             <= 5'd0;
            out.button_num  <= 5'd0;
            out.button_size <= 7'd0;
            out.board_size  <= 10'd0;
            out.board_xpos  <= 11'd0;
            out.board_ypos  <= 11'd0;
        end else begin
            latch_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (level_valid && level != 2'd0) begin
                        num   <= tbl_num;
                        size  <= tbl_size;
                        acc   <= 10'd0;
                        cnt   <= 5'd0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc + {3'b000, size};
                    cnt <= cnt + 5'd1;
                    if (cnt == num - 5'd1) begin
                        state <= CENTER;
                    end
                end
                CENTER: begin
                    out.button_num  <= num;
                    out.button_size <= size;
                    out.board_size  <= acc;
                    out.board_xpos  <= x_pos;
                    out.board_ypos  <= y_pos;
                    state           <= DONE;
                end
                DONE: begin
                    latch_en <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_level_setup.sv
// Self-checking bench: a cycle-counting reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_game_level_setup;

    localparam int H = 1024;
    localparam int V = 768;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       level_valid = 1'b0;
    logic [1:0] level = 2'd0;
    logic       busy;
    logic       latch_en;

    game_set_if gs ();

    game_level_setup #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk         (clk),
        .rst         (rst),
        .level_valid (level_valid),
        .level       (level),
        .busy        (busy),
        .latch_en    (latch_en),
        .out         (gs)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int pulses = 0;

    task automatic checkOutput(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference model: timing counted in clock edges from the accepted strobe.
    int cyc = 0;
    int center_cyc = -1;
    int latch_cyc = -1;
    bit m_active = 0;
    bit model_valid = 0;
    int m_num = 0, m_size = 0, board = 0;
    int e_busy = 0, e_latch = 0, e_num = 0, e_size = 0, e_board = 0, e_x = 0, e_y = 0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_active = 0; center_cyc = -1; latch_cyc = -1;
            e_busy = 0; e_latch = 0; e_num = 0; e_size = 0;
            e_board = 0; e_x = 0; e_y = 0;
            model_valid = 1;
        end else begin
            e_latch = 0;
            if (!m_active && level_valid && level != 2'd0) begin
                m_active = 1;
                case (level)
                    2'd1:    begin m_num = 8;  m_size = 64; end
                    2'd2:    begin m_num = 12; m_size = 48; end
                    default: begin m_num = 16; m_size = 40; end
                endcase
                center_cyc = cyc + m_num + 1;
                latch_cyc  = cyc + m_num + 2;
            end else if (m_active && cyc == center_cyc) begin
                board   = m_num * m_size;
                e_num   = m_num;
                e_size  = m_size;
                e_board = board;
                e_x     = (board >= H) ? 0 : (H - board) / 2;
                e_y     = (board >= V) ? 0 : (V - board) / 2;
            end else if (m_active && cyc == latch_cyc) begin
                m_active = 0;
                e_latch  = 1;
            end
            e_busy = m_active;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            checkOutput("busy", int'(busy), e_busy);
            checkOutput("latch_en", int'(latch_en), e_latch);
            checkOutput("button_num", int'(gs.button_num), e_num);
            checkOutput("button_size", int'(gs.button_size), e_size);
            checkOutput("board_size", int'(gs.board_size), e_board);
            checkOutput("board_xpos", int'(gs.board_xpos), e_x);
            checkOutput("board_ypos", int'(gs.board_ypos), e_y);
        end
        if (latch_en) pulses++;
    end

    // Drives a one-cycle strobe; returns on the negedge right after it was sampled.
    task automatic applyStimulus(input logic [1:0] lv);
        level_valid = 1'b1;
        level       = lv;
        @(negedge clk);
        level_valid = 1'b0;
        level       = 2'd0;
    endtask

    task automatic waitLatch(input string name, input int req_lat);
        int lat = 0;
        while (!latch_en && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checkOutput(name, lat, req_lat);
    endtask

    task automatic checkBundle(input string name, input int n, input int s,
                               input int b, input int x, input int y);
        checkOutput({name, "_num"},   int'(gs.button_num),  n);
        checkOutput({name, "_size"},  int'(gs.button_size), s);
        checkOutput({name, "_board"}, int'(gs.board_size),  b);
        checkOutput({name, "_xpos"},  int'(gs.board_xpos),  x);
        checkOutput({name, "_ypos"},  int'(gs.board_ypos),  y);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int p0;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        checkOutput("reset_busy", int'(busy), 0);
        checkBundle("reset", 0, 0, 0, 0, 0);

        applyStimulus(2'd0);
        idle(2);
        checkOutput("invalid_level_busy", int'(busy), 0);

        applyStimulus(2'd1);
        waitLatch("easy_latency", 10);
        checkBundle("easy", 8, 64, 512, 256, 128);
        applyStimulus(2'd3);
        checkOutput("b2b_accepted_busy", int'(busy), 1);
        waitLatch("b2b_hard_latency", 18);
        checkBundle("b2b_hard", 16, 40, 640, 192, 64);
        idle(3);

        p0 = pulses;
        applyStimulus(2'd2);
        waitLatch("medium_latency", 14);
        checkBundle("medium", 12, 48, 576, 224, 96);
        idle(20);
        checkOutput("medium_pulse_count", pulses - p0, 1);

        p0 = pulses;
        applyStimulus(2'd3);
        idle(4);
        applyStimulus(2'd1);
        waitLatch("hard_latency_with_drop", 13);
        checkBundle("hard_drop", 16, 40, 640, 192, 64);
        idle(25);
        checkOutput("hard_drop_pulse_count", pulses - p0, 1);

        p0 = pulses;
        applyStimulus(2'd2);
        waitLatch("medium_again_latency", 14);
        checkBundle("medium_again", 12, 48, 576, 224, 96);
        idle(3);

        p0 = pulses;
        applyStimulus(2'd3);
        idle(5);
        rst = 1'b1;
        idle(3);
        checkOutput("rst_mid_busy", int'(busy), 0);
        checkOutput("rst_mid_latch", int'(latch_en), 0);
        checkBundle("rst_mid", 0, 0, 0, 0, 0);
        rst = 1'b0;
        idle(30);
        checkOutput("rst_mid_pulse_count", pulses - p0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
